// File: rtl/axis_arb_pkg.sv
// Shared constants for the stereo AXI-Stream arbiter: default sample width,
// source encoding and the grant state type.
package axis_arb_pkg;

    localparam int AXIS_DATA_WIDTH = 24;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    typedef enum logic {
        GRANT0 = 1'b0,
        GRANT1 = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for a slow asynchronous level (DIP switch).
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/axis_stereo_arbiter.sv
// Two-source stereo AXI-Stream arbiter; grant moves only between frames.
// Build option AXIS_ARB_DRAIN_EN: the non-granted source is accepted and discarded.
module axis_stereo_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel,
    input  logic [DATA_WIDTH-1:0] s0_axis_data,
    input  logic                  s0_axis_valid,
    output logic                  s0_axis_ready,
    input  logic                  s0_axis_last,
    input  logic [DATA_WIDTH-1:0] s1_axis_data,
    input  logic                  s1_axis_valid,
    output logic                  s1_axis_ready,
    input  logic                  s1_axis_last,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    output logic                  grant
);

    logic                  sel_s;
    arb_state_e            state_q, state_d;
    logic [1:0]            open_q, open_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;

    logic                  grant_cur;
    logic                  out_rdy;
    logic                  idle_rdy;
    logic                  acc0, acc1;
    logic                  frames_closed;

    sync_2ff u_sel_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (sel),
        .q_o   (sel_s)
    );

    assign grant_cur = (state_q == GRANT1);
    assign out_rdy   = !m_valid_q || m_axis_ready;

`ifdef AXIS_ARB_DRAIN_EN
    assign idle_rdy = 1'b1;
`else
    assign idle_rdy = 1'b0;
`endif

    assign s0_axis_ready = (grant_cur == SRC0) ? out_rdy : idle_rdy;
    assign s1_axis_ready = (grant_cur == SRC1) ? out_rdy : idle_rdy;

    assign acc0 = s0_axis_valid && s0_axis_ready;
    assign acc1 = s1_axis_valid && s1_axis_ready;

    // Both flags closed after this edge means neither stream is mid-frame.
    assign frames_closed = (open_d == 2'b00);

    always_comb begin
        open_d    = open_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        state_d   = state_q;

        if (acc0) open_d[0] = !s0_axis_last;
        if (acc1) open_d[1] = !s1_axis_last;

        if ((grant_cur == SRC0) && acc0) begin
            m_data_d  = s0_axis_data;
            m_last_d  = s0_axis_last;
            m_valid_d = 1'b1;
        end else if ((grant_cur == SRC1) && acc1) begin
            m_data_d  = s1_axis_data;
            m_last_d  = s1_axis_last;
            m_valid_d = 1'b1;
        end else if (m_axis_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            GRANT0:  if ((sel_s == SRC1) && frames_closed) state_d = GRANT1;
            GRANT1:  if ((sel_s == SRC0) && frames_closed) state_d = GRANT0;
            default: state_d = GRANT0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= GRANT0;
            open_q    <= 2'b00;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            open_q    <= open_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_axis_data  = m_data_q;
    assign m_axis_valid = m_valid_q;
    assign m_axis_last  = m_last_q;
    assign grant        = grant_cur;

endmodule

// File: tb/tb_axis_stereo_arbiter.sv
// Scoreboard bench for axis_stereo_arbiter: directed scenarios then random traffic.
module tb_axis_stereo_arbiter;

    localparam int DW = 24;

`ifdef AXIS_ARB_DRAIN_EN
    localparam logic IDLE_RDY = 1'b1;
`else
    localparam logic IDLE_RDY = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sel = 1'b0;
    logic [DW-1:0] s0_axis_data = '0;
    logic          s0_axis_valid = 1'b0;
    logic          s0_axis_ready;
    logic          s0_axis_last = 1'b0;
    logic [DW-1:0] s1_axis_data = '0;
    logic          s1_axis_valid = 1'b0;
    logic          s1_axis_ready;
    logic          s1_axis_last = 1'b0;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_valid;
    logic          m_axis_ready = 1'b1;
    logic          m_axis_last;
    logic          grant;

    always #5 clk = ~clk;

    axis_stereo_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .sel           (sel),
        .s0_axis_data  (s0_axis_data),
        .s0_axis_valid (s0_axis_valid),
        .s0_axis_ready (s0_axis_ready),
        .s0_axis_last  (s0_axis_last),
        .s1_axis_data  (s1_axis_data),
        .s1_axis_valid (s1_axis_valid),
        .s1_axis_ready (s1_axis_ready),
        .s1_axis_last  (s1_axis_last),
        .m_axis_data   (m_axis_data),
        .m_axis_valid  (m_axis_valid),
        .m_axis_ready  (m_axis_ready),
        .m_axis_last   (m_axis_last),
        .grant         (grant)
    );

    int    errors = 0;
    int    checks = 0;
    beat_t src0_q[$];
    beat_t src1_q[$];
    beat_t exp_q[$];
    int    vld_pct = 100;
    bit    rdy_rand = 1'b0;
    bit    rdy_force = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // ---------------- source drivers and sink ----------------
    bit acc0_seen = 1'b0;
    bit acc1_seen = 1'b0;

    always @(posedge clk) begin
        acc0_seen = 1'b0;
        acc1_seen = 1'b0;
        if (!reset && s0_axis_valid && s0_axis_ready) begin
            void'(src0_q.pop_front());
            acc0_seen = 1'b1;
        end
        if (!reset && s1_axis_valid && s1_axis_ready) begin
            void'(src1_q.pop_front());
            acc1_seen = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!(s0_axis_valid && !acc0_seen)) begin
            if (src0_q.size() > 0 && $urandom_range(99) < vld_pct) begin
                s0_axis_valid = 1'b1;
                s0_axis_data  = src0_q[0].data;
                s0_axis_last  = src0_q[0].last;
            end else begin
                s0_axis_valid = 1'b0;
            end
        end
        if (!(s1_axis_valid && !acc1_seen)) begin
            if (src1_q.size() > 0 && $urandom_range(99) < vld_pct) begin
                s1_axis_valid = 1'b1;
                s1_axis_data  = src1_q[0].data;
                s1_axis_last  = src1_q[0].last;
            end else begin
                s1_axis_valid = 1'b0;
            end
        end
        m_axis_ready = rdy_rand ? ($urandom_range(99) < 75) : rdy_force;
    end

    // ---------------- reference model: grant, frames, expected beats ----------------
    bit       m_grant = 1'b0;
    bit [1:0] m_open = 2'b00;
    bit       m_sync1 = 1'b0;
    bit       m_sync2 = 1'b0;
    bit       lat_pend = 1'b0;
    beat_t    lat_beat;

    always @(posedge clk) begin
        bit a0, a1, gr_rdy;
        if (reset) begin
            exp_q.delete();
            m_grant  = 1'b0;
            m_open   = 2'b00;
            m_sync1  = 1'b0;
            m_sync2  = 1'b0;
            lat_pend = 1'b0;
        end else begin
            gr_rdy = !m_axis_valid || m_axis_ready;
            chk("s0_ready", s0_axis_ready, (m_grant == 1'b0) ? gr_rdy : IDLE_RDY);
            chk("s1_ready", s1_axis_ready, (m_grant == 1'b1) ? gr_rdy : IDLE_RDY);
            chk("grant", grant, m_grant);
            if (lat_pend) begin
                chk("latency_valid", m_axis_valid, 1'b1);
                chk("latency_data", m_axis_data, lat_beat.data);
                chk("latency_last", m_axis_last, lat_beat.last);
            end
            a0 = s0_axis_valid && s0_axis_ready;
            a1 = s1_axis_valid && s1_axis_ready;
            lat_pend = 1'b0;
            if (m_grant == 1'b0 && a0) begin
                lat_beat = '{data: s0_axis_data, last: s0_axis_last};
                lat_pend = 1'b1;
                exp_q.push_back(lat_beat);
            end
            if (m_grant == 1'b1 && a1) begin
                lat_beat = '{data: s1_axis_data, last: s1_axis_last};
                lat_pend = 1'b1;
                exp_q.push_back(lat_beat);
            end
            if (a0) m_open[0] = !s0_axis_last;
            if (a1) m_open[1] = !s1_axis_last;
            // switch only when requested and neither stream is inside a frame
            if (m_sync2 != m_grant && m_open == 2'b00) m_grant = m_sync2;
            m_sync2 = m_sync1;
            m_sync1 = sel;
        end
    end

    // ---------------- output monitor ----------------
    bit    stall_prev = 1'b0;
    beat_t held;

    always @(posedge clk) begin
        beat_t e;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", m_axis_valid, 1'b1);
                chk("stall_data", m_axis_data, held.data);
                chk("stall_last", m_axis_last, held.last);
            end
            if (m_axis_valid && m_axis_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_beat: got unexpected %0h/%0b, expected none (t=%0t)",
                             m_axis_data, m_axis_last, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", m_axis_data, e.data);
                    chk("out_last", m_axis_last, e.last);
                end
            end
            stall_prev = m_axis_valid && !m_axis_ready;
            held = '{data: m_axis_data, last: m_axis_last};
        end
    end

    // ---------------- helpers ----------------
    task automatic push(input bit src, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b = '{data: d, last: l};
        if (src) src1_q.push_back(b);
        else     src0_q.push_back(b);
    endtask

    task automatic wait_src_empty(input bit src, input int budget);
        int n = 0;
        while (((src ? src1_q.size() : src0_q.size()) != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) timeout_fail("src_empty");
        @(negedge clk);
    endtask

    task automatic wait_grant(input logic g, input int budget);
        int n = 0;
        while (grant !== g && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("grant_reached", grant, g);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((src0_q.size() != 0 || src1_q.size() != 0 || m_axis_valid ||
                s0_axis_valid || s1_axis_valid) && n < budget) begin
            if (src1_q.size() != 0 && src0_q.size() == 0) sel = 1'b1;
            else if (src0_q.size() != 0 && src1_q.size() == 0) sel = 1'b0;
            @(negedge clk);
            n++;
        end
        if (n >= budget) timeout_fail("idle");
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", m_axis_valid, 1'b0);
        chk("rst_data", m_axis_data, 24'h0);
        chk("rst_last", m_axis_last, 1'b0);
        chk("rst_grant", grant, 1'b0);
        reset = 1'b0;

        // basic frame from s0
        push(0, 24'h000111, 1'b0);
        push(0, 24'h000222, 1'b1);
        wait_idle(200);

        // select raised mid-frame: s0 R must come out before s1 L
        push(0, 24'h0000AA, 1'b0);
        wait_src_empty(0, 100);
        sel = 1'b1;
        repeat (4) @(negedge clk);
        chk("midframe_grant_hold", grant, 1'b0);
        push(0, 24'h0000BB, 1'b1);
        wait_grant(1'b1, 100);
        push(1, 24'h00CC00, 1'b0);
        push(1, 24'h00DD00, 1'b1);
        wait_idle(200);

        // one-cycle glitch on sel while s1 is held mid-frame
        rdy_force = 1'b0;
        push(1, 24'h0A0A0A, 1'b0);
        wait_src_empty(1, 100);
        sel = 1'b0;
        @(negedge clk);
        sel = 1'b1;
        repeat (5) @(negedge clk);
        chk("glitch_grant", grant, 1'b1);
        rdy_force = 1'b1;
        push(1, 24'h0B0B0B, 1'b1);
        wait_idle(200);

        // backpressure
        rdy_force = 1'b0;
        push(1, 24'h123456, 1'b0);
        push(1, 24'h654321, 1'b1);
        repeat (7) @(negedge clk);
        chk("bp_valid", m_axis_valid, 1'b1);
        chk("bp_data", m_axis_data, 24'h123456);
        chk("bp_ready", s1_axis_ready, 1'b0);
        rdy_force = 1'b1;
        wait_idle(200);

        // non-granted source behaviour
        sel = 1'b0;
        wait_grant(1'b0, 100);
`ifdef AXIS_ARB_DRAIN_EN
        for (int i = 0; i < 10; i++) push(1, 24'h510000 + 24'(i), 1'(i % 2));
        wait_src_empty(1, 200);
        push(1, 24'h51AAAA, 1'b0);
        wait_src_empty(1, 100);
        sel = 1'b1;
        repeat (6) @(negedge clk);
        chk("drain_switch_wait", grant, 1'b0);
        push(1, 24'h51BBBB, 1'b1);
        wait_grant(1'b1, 100);
        push(1, 24'h51CCCC, 1'b0);
        push(1, 24'h51DDDD, 1'b1);
        wait_idle(200);
`else
        for (int i = 0; i < 10; i++) push(1, 24'h510000 + 24'(i), 1'(i % 2));
        repeat (10) @(negedge clk);
        chk("stall_s1_count", src1_q.size(), 10);
        sel = 1'b1;
        wait_idle(300);
`endif

        // reset while a beat is in the output register and s0 is mid-frame
        sel = 1'b0;
        wait_grant(1'b0, 100);
        rdy_force = 1'b0;
        push(0, 24'h0000A1, 1'b0);
        wait_src_empty(0, 100);
        chk("pre_rst_valid", m_axis_valid, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_valid", m_axis_valid, 1'b0);
        chk("midrst_grant", grant, 1'b0);
        reset = 1'b0;
        rdy_force = 1'b1;
        sel = 1'b1;
        wait_grant(1'b1, 100);
        push(1, 24'h00E100, 1'b0);
        push(1, 24'h00E200, 1'b1);
        wait_idle(200);
        sel = 1'b0;
        wait_grant(1'b0, 100);
        push(0, 24'h0000F1, 1'b0);
        push(0, 24'h0000F2, 1'b1);
        wait_idle(200);

        // random traffic
        rdy_rand = 1'b1;
        vld_pct = 70;
        for (int it = 0; it < 300; it++) begin
            bit src;
            src = 1'($urandom_range(1));
            if ($urandom_range(3) == 0) begin
                push(src, 24'($urandom), 1'b1);
            end else begin
                push(src, 24'($urandom), 1'b0);
                push(src, 24'($urandom), 1'b1);
            end
            if ($urandom_range(9) == 0) sel = ~sel;
            repeat ($urandom_range(4)) @(negedge clk);
        end
        wait_idle(5000);
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
